// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M mul/div sequencer: funct3 op codes, FSM states and the
// architectural constants used by the divide special cases.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    typedef enum logic [2:0] {
        StQuiesce,
        StIdle,
        StMulWait,
        StDivWait,
        StDivDrain,
        StDone
    } state_e;

endpackage

// File: rtl/muldiv_sign.sv
// Sign handling around the unsigned IPs: operand magnitudes, result-sign decision for the
// request op, and a 64-bit conditional negate for the returned product/quotient/remainder.
module muldiv_sign
    import muldiv_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        fix_neg,
    input  logic [63:0] raw,
    output logic [31:0] mag1,
    output logic [31:0] mag2,
    output logic        res_neg,
    output logic [63:0] fixed
);

    logic rs1_signed;
    logic rs2_signed;
    logic rs1_neg;
    logic rs2_neg;

    always_comb begin
        // MUL is treated as signed x signed; the low product word is identical either way.
        rs1_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                     (op == OP_DIV) || (op == OP_REM);
        rs2_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        rs1_neg    = rs1_signed && rs1[31];
        rs2_neg    = rs2_signed && rs2[31];
        mag1       = rs1_neg ? (32'd0 - rs1) : rs1;
        mag2       = rs2_neg ? (32'd0 - rs2) : rs2;
        // Remainder follows the dividend; products and quotients follow the sign product.
        res_neg    = (op == OP_REM) ? rs1_neg : (rs1_neg ^ rs2_neg);
        fixed      = fix_neg ? (64'd0 - raw) : raw;
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M sequencer: takes one mul/div request, drives the unsigned multiplier and divider IPs,
// applies RISC-V sign and special-case rules, handles flush/drain and returns one result.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 36
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic        flush,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_ce,
    input  logic [63:0] mul_p,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    output logic        div_valid,
    input  logic [63:0] div_dout,
    input  logic        div_dout_valid
);

    localparam int unsigned CntMax = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic              special_q, special_d;
    logic [31:0]       spec_res_q, spec_res_d;
    logic [31:0]       mul_a_q, mul_a_d;
    logic [31:0]       mul_b_q, mul_b_d;
    logic [31:0]       dividend_q, dividend_d;
    logic [31:0]       divisor_q, divisor_d;
    logic              div_valid_q, div_valid_d;
    logic [31:0]       resp_data_q, resp_data_d;

    logic [31:0]       mag1;
    logic [31:0]       mag2;
    logic              res_neg;
    logic [63:0]       raw;
    logic [63:0]       fixed;
    logic [31:0]       mul_result;
    logic              accept;
    logic              div_zero;
    logic              div_ovf;

    muldiv_sign u_sign (
        .op      (req_op),
        .rs1     (req_rs1),
        .rs2     (req_rs2),
        .fix_neg (neg_q),
        .raw     (raw),
        .mag1    (mag1),
        .mag2    (mag2),
        .res_neg (res_neg),
        .fixed   (fixed)
    );

    always_comb begin
        // op_q[1] separates REM/REMU (remainder half) from DIV/DIVU (quotient half).
        if (state_q == StMulWait) begin
            raw = mul_p;
        end else begin
            raw = {32'd0, op_q[1] ? div_dout[31:0] : div_dout[63:32]};
        end
        mul_result = (op_q == OP_MUL) ? fixed[31:0] : fixed[63:32];
    end

    assign accept   = (state_q == StIdle) && req_valid && !flush;
    assign div_zero = (req_rs2 == 32'd0);
    assign div_ovf  = ((req_op == OP_DIV) || (req_op == OP_REM)) &&
                      (req_rs1 == INT_MIN) && (req_rs2 == 32'hFFFF_FFFF);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        neg_d       = neg_q;
        special_d   = special_q;
        spec_res_d  = spec_res_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        div_valid_d = 1'b0;
        resp_data_d = resp_data_q;

        unique case (state_q)
            StQuiesce: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StIdle: begin
                if (accept) begin
                    op_d  = req_op;
                    neg_d = res_neg;
                    if (!req_op[2]) begin
                        mul_a_d = mag1;
                        mul_b_d = mag2;
                        cnt_d   = CntW'(MUL_LAT);
                        state_d = StMulWait;
                    end else if (div_zero || div_ovf) begin
                        // Resolved without the divider; DIV_WAIT spends one cycle to return it.
                        special_d  = 1'b1;
                        spec_res_d = div_zero ? (req_op[1] ? req_rs1 : DIV0_QUOT)
                                              : (req_op[1] ? 32'd0 : INT_MIN);
                        state_d    = StDivWait;
                    end else begin
                        special_d   = 1'b0;
                        dividend_d  = mag1;
                        divisor_d   = mag2;
                        div_valid_d = 1'b1;
                        state_d     = StDivWait;
                    end
                end
            end
            StMulWait: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    resp_data_d = mul_result;
                    state_d     = StDone;
                end
            end
            StDivWait: begin
                if (special_q) begin
                    if (flush) begin
                        state_d = StIdle;
                    end else begin
                        resp_data_d = spec_res_q;
                        state_d     = StDone;
                    end
                end else if (div_dout_valid) begin
                    if (!flush) begin
                        resp_data_d = fixed[31:0];
                    end
                    state_d = flush ? StIdle : StDone;
                end else if (flush) begin
                    // The divider still owes us a result; wait for it so it is not misattributed.
                    state_d = StDivDrain;
                end
            end
            StDivDrain: begin
                if (div_dout_valid) begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StQuiesce;
                cnt_d   = CntW'(DIV_LAT);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StQuiesce;
            cnt_q       <= CntW'(DIV_LAT);
            op_q        <= 3'd0;
            neg_q       <= 1'b0;
            special_q   <= 1'b0;
            spec_res_q  <= 32'd0;
            mul_a_q     <= 32'd0;
            mul_b_q     <= 32'd0;
            dividend_q  <= 32'd0;
            divisor_q   <= 32'd0;
            div_valid_q <= 1'b0;
            resp_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            neg_q       <= neg_d;
            special_q   <= special_d;
            spec_res_q  <= spec_res_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            div_valid_q <= div_valid_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign req_ready    = (state_q == StIdle);
    assign resp_valid   = (state_q == StDone) && !flush;
    assign resp_data    = resp_data_q;
    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;
    assign mul_ce       = (state_q == StMulWait) && (cnt_q != '0);
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;
    assign div_valid    = div_valid_q;

    div_dout_valid_when_expected: assert property (@(posedge clk) disable iff (rst)
        div_dout_valid |-> (state_q inside {StQuiesce, StDivWait, StDivDrain}));

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: behavioural multiplier/divider IP models, directed cases and random
// ops checked against an arithmetic RV32M reference.
module tb_muldiv_ctrl;

    localparam int unsigned MulLat      = 4;
    localparam int unsigned DivLat      = 36;
    localparam int          DivModelLat = 10;

    localparam logic [2:0] OpMul    = 3'd0;
    localparam logic [2:0] OpMulh   = 3'd1;
    localparam logic [2:0] OpMulhsu = 3'd2;
    localparam logic [2:0] OpMulhu  = 3'd3;
    localparam logic [2:0] OpDiv    = 3'd4;
    localparam logic [2:0] OpDivu   = 3'd5;
    localparam logic [2:0] OpRem    = 3'd6;
    localparam logic [2:0] OpRemu   = 3'd7;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        flush;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_ce;
    logic [63:0] mul_p;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_valid;
    logic [63:0] div_dout;
    logic        div_dout_valid;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_ctrl #(
        .MUL_LAT (MulLat),
        .DIV_LAT (DivLat)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_rs1        (req_rs1),
        .req_rs2        (req_rs2),
        .flush          (flush),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .mul_a          (mul_a),
        .mul_b          (mul_b),
        .mul_ce         (mul_ce),
        .mul_p          (mul_p),
        .div_dividend   (div_dividend),
        .div_divisor    (div_divisor),
        .div_valid      (div_valid),
        .div_dout       (div_dout),
        .div_dout_valid (div_dout_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier IP: MulLat CE-gated register stages.
    logic [63:0] pipe [MulLat];
    always @(posedge clk) begin
        if (mul_ce) begin
            pipe[0] <= 64'(mul_a) * 64'(mul_b);
            for (int i = 1; i < MulLat; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign mul_p = pipe[MulLat-1];

    // Divider IP: fixed latency, keeps running through controller reset.
    logic        dpend = 1'b0;
    int          dcnt = 0;
    logic [63:0] dres = '0;
    logic [31:0] ip_dividend = '0;
    logic [31:0] ip_divisor = '0;
    initial begin
        div_dout       = '0;
        div_dout_valid = 1'b0;
    end
    always @(posedge clk) begin
        div_dout_valid <= 1'b0;
        if (div_valid) begin
            dpend       <= 1'b1;
            dcnt        <= DivModelLat - 1;
            ip_dividend <= div_dividend;
            ip_divisor  <= div_divisor;
            dres <= (div_divisor == 0) ? 64'd0 :
                    {div_dividend / div_divisor, div_dividend % div_divisor};
        end else if (dpend) begin
            if (dcnt == 0) begin
                dpend          <= 1'b0;
                div_dout_valid <= 1'b1;
                div_dout       <= dres;
            end else begin
                dcnt <= dcnt - 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa, sb, ua, ub, r;
        logic [63:0] p;
        bit          ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'(a);
        ub  = longint'(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            OpMul:    r = ua * ub;
            OpMulh:   r = (sa * sb) >>> 32;
            OpMulhsu: r = (sa * ub) >>> 32;
            OpMulhu:  begin p = 64'(ua) * 64'(ub); r = longint'(p >> 32); end
            OpDiv:    r = (b == 0) ? -1 : (ovf ? sa : sa / sb);
            OpDivu:   r = (b == 0) ? -1 : ua / ub;
            OpRem:    r = (b == 0) ? sa : (ovf ? 0 : sa % sb);
            default:  r = (b == 0) ? ua : ua % ub;
        endcase
        return 32'(r);
    endfunction

    function automatic logic [31:0] magnitude(input logic [31:0] v, input bit sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            4:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) check_eq("issue_ready", 64'(req_ready), 64'd1);
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Cycle numbering: the accept edge closes cycle 0.
    task automatic collect(output logic [31:0] data, output bit got, output int lat,
                           output int ce_cnt, output int dv_cnt, output int dvo);
        data = '0; got = 1'b0; lat = 1; ce_cnt = 0; dv_cnt = 0; dvo = -1;
        while (!got && lat < 200) begin
            @(negedge clk);
            if (mul_ce) ce_cnt++;
            if (div_valid) dv_cnt++;
            if (div_dout_valid) dvo = lat;
            if (resp_valid) begin
                got  = 1'b1;
                data = resp_data;
            end else begin
                lat++;
            end
        end
        @(negedge clk);
        check_eq("resp_one_cycle", 64'(resp_valid), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        logic [31:0] data;
        bit          got, special, sgn;
        int          lat, ce_cnt, dv_cnt, dvo;
        issue(op, a, b);
        collect(data, got, lat, ce_cnt, dv_cnt, dvo);
        sgn     = (op == OpDiv) || (op == OpRem);
        special = (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        check_eq({tag, "_resp"}, 64'(got), 64'd1);
        check_eq({tag, "_data"}, 64'(data), 64'(exp));
        if (!op[2]) begin
            check_eq({tag, "_lat"}, 64'(lat), 64'(MulLat + 2));
            check_eq({tag, "_ce_cycles"}, 64'(ce_cnt), 64'(MulLat));
        end else if (special) begin
            check_eq({tag, "_lat"}, 64'(lat), 64'd2);
            check_eq({tag, "_div_pulses"}, 64'(dv_cnt), 64'd0);
        end else begin
            check_eq({tag, "_lat"}, 64'(lat), 64'(dvo + 1));
            check_eq({tag, "_div_pulses"}, 64'(dv_cnt), 64'd1);
            check_eq({tag, "_ip_dividend"}, 64'(ip_dividend), 64'(magnitude(a, sgn)));
            check_eq({tag, "_ip_divisor"}, 64'(ip_divisor), 64'(magnitude(b, sgn)));
        end
    endtask

    task automatic check_reset_and_quiesce(input string tag);
        int lows = 0;
        int resps = 0;
        @(negedge clk);
        check_eq({tag, "_ctrl_outs"}, 64'({req_ready, resp_valid, mul_ce, div_valid}), 64'd0);
        check_eq({tag, "_resp_data"}, 64'(resp_data), 64'd0);
        check_eq({tag, "_mul_ops"}, {mul_a, mul_b}, 64'd0);
        check_eq({tag, "_div_ops"}, {div_dividend, div_divisor}, 64'd0);
        rst = 1'b0;
        while (!req_ready && lows < 200) begin
            if (resp_valid) resps++;
            lows++;
            @(negedge clk);
        end
        check_eq({tag, "_quiesce_cycles"}, 64'(lows), 64'(DivLat + 1));
        check_eq({tag, "_quiesce_resp"}, 64'(resps), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          early, resps, guard;
        logic [2:0]  op;
        logic [31:0] a, b;

        rst = 1'b1; req_valid = 1'b0; flush = 1'b0;
        req_op = '0; req_rs1 = '0; req_rs2 = '0;
        repeat (3) @(posedge clk);
        check_reset_and_quiesce("por");

        run_op("mul_neg",   OpMul,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulh_min",  OpMulh,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
        run_op("mulhsu",    OpMulhsu, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhu",     OpMulhu,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("div_neg",   OpDiv,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        run_op("rem_neg",   OpRem,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        run_op("divu",      OpDivu,   32'hFFFF_FFFE,  32'd3,         32'h5555_5554);
        run_op("div_zero",  OpDiv,    32'd5,          32'd0,         32'hFFFF_FFFF);
        run_op("remu_zero", OpRemu,   32'd5,          32'd0,         32'd5);
        run_op("div_ovf",   OpDiv,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf",   OpRem,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0);

        // Flush during DIV_WAIT: no response, drain until the divider answers.
        issue(OpDiv, 32'd1000, 32'd3);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        early = 0; resps = 0; guard = 0;
        while (guard < 60) begin
            @(negedge clk);
            if (resp_valid) resps++;
            if (div_dout_valid) break;
            if (req_ready) early++;
            guard++;
        end
        check_eq("drain_saw_dout", 64'(div_dout_valid), 64'd1);
        check_eq("drain_ready_low", 64'(early + int'(req_ready)), 64'd0);
        check_eq("drain_no_resp", 64'(resps), 64'd0);
        @(negedge clk);
        check_eq("drain_to_idle", 64'(req_ready), 64'd1);
        run_op("after_drain", OpDivu, 32'd100, 32'd7, 32'd14);

        // Flush during MUL_WAIT.
        issue(OpMul, 32'd3, 32'd5);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        resps = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp_valid) resps++;
        end
        check_eq("mulflush_no_resp", 64'(resps), 64'd0);
        check_eq("mulflush_idle", 64'(req_ready), 64'd1);
        run_op("after_mulflush", OpMulhu, 32'h1234_5678, 32'h9ABC_DEF0,
               ref_op(OpMulhu, 32'h1234_5678, 32'h9ABC_DEF0));

        // Flush in DONE suppresses the strobe.
        issue(OpMul, 32'd6, 32'd7);
        repeat (MulLat + 2) @(negedge clk);
        flush = 1'b1;
        #1 check_eq("done_flush_suppress", 64'(resp_valid), 64'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check_eq("done_flush_idle", 64'(req_ready), 64'd1);

        // Flush together with a request in IDLE: not accepted.
        @(negedge clk);
        req_op = OpMul; req_rs1 = 32'd2; req_rs2 = 32'd2;
        req_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 begin req_valid = 1'b0; flush = 1'b0; end
        @(negedge clk);
        check_eq("idle_flush_no_accept", 64'({req_ready, mul_ce}), 64'b10);

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, ref_op(op, a, b));
        end

        // Reset in the middle of a divide; the stale divider result lands in QUIESCE.
        issue(OpDiv, 32'd1000, 32'd7);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        check_reset_and_quiesce("mid_rst");
        run_op("post_rst", OpDiv, 32'hFFFF_FF9C, 32'd7, ref_op(OpDiv, 32'hFFFF_FF9C, 32'd7));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencer for the RV32M extension. Accepts one mul/div request from the core execute stage.
- Drives the pipelined multiplier IP (mul: CLK/A/B/CE/P) and the AXI-stream divider IP (div), both of which run unsigned.
- Performs sign conversion, RISC-V special cases (divide by zero, signed overflow) and flush/drain.
- Returns one 32-bit result through a valid/ready handshake.

Parameters:
- MUL_LAT, 4: multiplier pipeline latency in CE-enabled cycles, A/B to P.
- DIV_LAT, 36: maximum divider latency in cycles; used only for the post-reset quiesce.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- req_rs1  in  32  operand 1 (multiplicand / dividend).
- req_rs2  in  32  operand 2 (multiplier / divisor).
- flush  in  1  abandon any in-flight op; no response is produced for it.
- resp_valid  out  1  one-cycle result strobe.
- resp_data  out  32  result.
- mul_a  out  32  multiplier A (unsigned magnitude), registered.
- mul_b  out  32  multiplier B, registered.
- mul_ce  out  1  multiplier clock enable.
- mul_p  in  64  multiplier product.
- div_dividend  out  32  dividend magnitude, registered.
- div_divisor  out  32  divisor magnitude, registered.
- div_valid  out  1  drives both s_axis tvalid inputs; one-cycle pulse.
- div_dout  in  64  [63:32] quotient, [31:0] remainder (unsigned).
- div_dout_valid  in  1  divider result strobe.
- The divider aclken is tied high by the parent.

Behaviour:
- Reset: all outputs 0. The state machine enters QUIESCE and counts DIV_LAT+1 cycles with req_ready=0, ignoring div_dout_valid, so a stale divider result from before reset is discarded. Then IDLE.
- States: QUIESCE, IDLE, MUL_WAIT, DIV_WAIT, DIV_DRAIN, DONE.
- Accept: req_valid && req_ready && !flush in IDLE. Operands are latched on that edge (cycle 0).
- Signed handling:
  - rs1 is signed for MULH, MULHSU, DIV, REM.
  - rs2 is signed for MULH, DIV, REM.
  - MUL uses magnitudes of both as signed (low word is sign-agnostic).
  - Magnitude = two's-complement negate when the operand is signed and negative; 0x80000000 maps to 0x80000000.
  - Result sign: product negated (64-bit) when exactly one signed operand is negative. Quotient negated when the dividend and divisor signs differ. Remainder takes the dividend's sign.
- MUL path:
  - Magnitudes go to mul_a/mul_b at accept; state MUL_WAIT, counter=MUL_LAT, mul_ce=1.
  - After MUL_LAT cycles, mul_p is sign-fixed. MUL takes [31:0]; MULH/MULHSU/MULHU take [63:32].
  - Result is registered, DONE entered, resp_valid=1 in cycle MUL_LAT+2.
  - mul_ce=0 outside MUL_WAIT.
- DIV path:
  - Divisor 0: no IP access. Quotient 0xFFFFFFFF (DIV/DIVU). Remainder = rs1 (REM/REMU). resp_valid in cycle 2.
  - Signed ops with rs1=0x80000000 and rs2=0xFFFFFFFF: DIV gives 0x80000000, REM gives 0, no IP access, resp_valid in cycle 2.
  - Otherwise: operands registered, div_valid pulses in cycle 1, state DIV_WAIT.
  - On div_dout_valid, the result is sign-fixed and registered; resp_valid follows in the next cycle.
- DONE: resp_valid=1 for exactly one cycle, then IDLE. resp_data holds until the next result. No backpressure; the consumer must take the result.
- Flush:
  - In MUL_WAIT: go to IDLE. The pipeline content is harmless, since every new op clocks MUL_LAT CE cycles.
  - In DIV_WAIT: go to DIV_DRAIN. Stay with req_ready=0 until div_dout_valid, drop that result, then go to IDLE.
  - flush coincident with div_dout_valid in DIV_WAIT: result dropped, go to IDLE.
  - In DONE: resp_valid is suppressed.
  - In IDLE together with req_valid: the request is not accepted.
- div_dout_valid in IDLE/MUL_WAIT/DONE is ignored. The assertion is that this never happens outside QUIESCE.
- rst overrides flush and all other inputs.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings (funct3 constants);
  - state encoding;
  - DIV0_QUOT=32'hFFFFFFFF;
  - INT_MIN=32'h80000000.
- Sub-module muldiv_sign: combinational. Computes operand magnitudes, sign flags and 64-bit result negation from op, rs1 and rs2.
- FSM, counters and IP interface stay in muldiv_ctrl.

Test Plan:
- MUL 7 × 0xFFFFFFFD (−3), MUL_LAT=4 → resp_valid in cycle 6, resp_data 0xFFFFFFEB; mul_ce high for exactly 4 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- Bench divider model with 10-cycle latency:
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD;
  - REM same → 0xFFFFFFFF;
  - DIVU 0xFFFFFFFE / 3 → 0x55555554;
  - IP receives magnitudes 7/2.
- DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same → 0. Each gives resp_valid in cycle 2 with no div_valid pulse.
- DIV issued, flush in cycle 3 → no resp_valid, req_ready low until div_dout_valid. A following DIVU 100/7 returns 14.
- rst asserted mid-DIV_WAIT → outputs 0, req_ready low for DIV_LAT+1 cycles, stale div_dout_valid during QUIESCE produces no response. First request after QUIESCE is correct.
